// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and the round-robin lane search used by the mux arbiter.
// Candidates are visited starting one past 'last', with an optional lane excluded.
package lab1_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    function automatic pick_t rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [1:0]         last,
        input logic               exclude_valid,
        input logic [1:0]         exclude_idx
    );
        pick_t      res;
        logic [1:0] cand;
        res = '0;
        // The final step wraps back onto 'last' itself, so it is the lowest priority.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = last + 2'(i);
            if (!res.found && req[cand] && !(exclude_valid && (cand == exclude_idx))) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux4_reg.sv
// Registered 4-to-1 lane mux; captures the selected lane only while a grant is active,
// otherwise holds its previous value with out_valid low.
module mux4_reg #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    input  logic [1:0]        s,
    input  logic              en,
    output logic [DATA_W-1:0] out,
    output logic              out_valid
);

    logic [DATA_W-1:0] lane;

    always_comb begin
        lane = a;
        case (s)
            2'd0:    lane = a;
            2'd1:    lane = b;
            2'd2:    lane = c;
            default: lane = d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (en) out <= lane;
            out_valid <= en;
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a registered 4-to-1 mux between four requesters,
// with a hold counter that forces rotation when a lane hogs the mux.
//
//  state | meaning
//  IDLE  | no lane granted, gnt = 0
//  GRANT | one lane owns the mux, gnt one-hot, s = owner index
module mux_rr_arbiter
    import lab1_arb_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    input  logic [DATA_W-1:0]  c,
    input  logic [DATA_W-1:0]  d,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         s,
    output logic [DATA_W-1:0]  out,
    output logic               out_valid
);

    localparam logic [3:0] HOLD_MAX = 4'(HOLD_CYCLES);

    state_t             state, state_nxt;
    logic [1:0]         last, last_nxt, s_nxt;
    logic [3:0]         hold_cnt, hold_cnt_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    pick_t              pick_idle, pick_other;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last     <= 2'd3;
            s        <= 2'd0;
            gnt      <= '0;
            hold_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            s        <= s_nxt;
            gnt      <= gnt_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        s_nxt        = s;
        gnt_nxt      = gnt;
        hold_cnt_nxt = hold_cnt;
        pick_idle    = rr_pick(req, last, 1'b0, 2'd0);
        // In GRANT the owner is always the last winner, so searching from s excludes it cleanly.
        pick_other   = rr_pick(req, s, 1'b1, s);

        case (state)
            IDLE: begin
                if (pick_idle.found) begin
                    state_nxt    = GRANT;
                    s_nxt        = pick_idle.idx;
                    last_nxt     = pick_idle.idx;
                    gnt_nxt      = 4'b0001 << pick_idle.idx;
                    hold_cnt_nxt = 4'd1;
                end
            end
            GRANT: begin
                if (!req[s] || (hold_cnt >= HOLD_MAX)) begin
                    if (pick_other.found) begin
                        s_nxt        = pick_other.idx;
                        last_nxt     = pick_other.idx;
                        gnt_nxt      = 4'b0001 << pick_other.idx;
                        hold_cnt_nxt = 4'd1;
                    end else if (!req[s]) begin
                        state_nxt    = IDLE;
                        gnt_nxt      = '0;
                        hold_cnt_nxt = 4'd0;
                    end else begin
                        hold_cnt_nxt = 4'd1;
                    end
                end else begin
                    hold_cnt_nxt = hold_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    mux4_reg #(.DATA_W(DATA_W)) u_mux (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .s         (s),
        .en        (state == GRANT),
        .out       (out),
        .out_valid (out_valid)
    );

endmodule
